instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Front end of the single-issue MIPS_32 datapath. Holds the program counter, fetches one 32-bit instruction at a time over a request/acknowledge instruction-memory port, and splits it into the opcode, register, funct and immediate fields that the ALU and register file consume. It closes the loop with the ALU by taking the ALU's branch decision and byte offset back in to compute the next PC. It stops on a halt instruction.

## Interface
Parameters
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- HALT_WORD, 32'hFFFF_FFFF, instruction word that stops fetching.

Ports
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  fetch request, held until acknowledged.
- imem_addr  out  32  byte address of the fetch; equals pc.
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  32  instruction word; sampled only when imem_req and imem_ack are both high.
- instr_valid  out  1  decoded fields are valid.
- opcode  out  6  instr[31:26].
- rs  out  5  instr[25:21].
- rt  out  5  instr[20:16].
- rd  out  5  instr[15:11].
- funct  out  6  instr[5:0].
- immediate  out  16  instr[15:0].
- pc  out  32  address of the instruction currently held.
- exec_done  in  1  downstream has consumed the held instruction; meaningful only while instr_valid is high.
- branch  in  1  ALU branch-taken flag; sampled with exec_done.
- branch_offset  in  32  signed byte offset from the ALU (immediate sign-extended and shifted left 2); sampled with exec_done.
- halted  out  1  halt instruction fetched; sticky until reset.

## Operation
- State machine states: IDLE, REQ, HOLD, HALT.
- IDLE: entered on reset. Always moves to REQ on the next cycle.
- REQ:
  - imem_req = 1 and imem_addr = pc.
  - When imem_ack is high, capture imem_rdata into the instruction register.
  - If the word equals HALT_WORD, go to HALT. Otherwise go to HOLD.
- HOLD:
  - instr_valid = 1; all field outputs are driven from the instruction register.
  - On exec_done:
    - pc <= pc + 4 + branch_offset when branch = 1, otherwise pc <= pc + 4.
    - Go to REQ.
- HALT:
  - halted = 1, imem_req = 0, instr_valid = 0.
  - pc stays at the halt instruction's address.
  - Only reset leaves this state.
- Arithmetic: 32-bit unsigned add, wraps modulo 2^32. The result's bits [1:0] are forced to 0.
- exec_done, branch and branch_offset are ignored in IDLE, REQ and HALT.
- branch = 1 without exec_done has no effect.
- imem_ack outside REQ is ignored.

## Timing
- Reset values:
  - pc = RESET_PC.
  - imem_req = 0, instr_valid = 0, halted = 0.
  - opcode, rs, rt, rd, funct and immediate all 0.
  - State = IDLE.
- imem_req rises 1 cycle after reset is released (IDLE to REQ).
- Fetch latency: an ack in cycle N gives instr_valid = 1 in cycle N+1. An ack in the same cycle the request starts is legal.
- exec_done in cycle M:
  - instr_valid = 0 and imem_req = 1 in cycle M+1, with the new pc.
  - Best-case throughput is 1 instruction every 2 cycles.
- Field outputs and pc are stable for as long as instr_valid = 1.
- Reset mid-operation (any state) wins over every other input:
  - Any outstanding request is abandoned.
  - An ack arriving in the same cycle as reset is discarded.
- Wrap-around: pc = 32'hFFFF_FFFC with no branch gives next pc = 0.

## Structure
- Shared package mips_pkg holds:
  - opcode constants: OP_RTYPE 6'b000000, OP_BEQ 6'b000100, OP_BNE 6'b000101, OP_BGEZ 6'b000001, OP_LUI 6'b001111;
  - the state enum (IDLE, REQ, HOLD, HALT);
  - the HALT_WORD default.
- One sub-module, next_pc_calc: combinational. Inputs pc, branch, branch_offset; output next pc with bits [1:0] cleared.
- Field extraction is done inline.

## Test plan
- Reset with zero-wait memory → imem_req high 1 cycle after reset; addr 0; instr 32'h2008_0005 gives opcode 001000, rs 0, rt 8, immediate 5 one cycle after ack.
- Ack delayed by 3 cycles → imem_addr and imem_req stay constant; instr_valid stays 0 until the cycle after ack.
- pc = 0x10, exec_done with branch = 1, branch_offset = 32'hFFFF_FFF8 → next imem_addr = 0x0C. With branch = 0 → next imem_addr = 0x14.
- branch = 1 pulsed with no exec_done, and exec_done pulsed during REQ → pc unchanged, no extra fetch.
- Fetch 32'hFFFF_FFFF at pc 0x20 → halted = 1, imem_req = 0 and pc = 0x20 held for 10 cycles. Then reset → pc = RESET_PC, halted = 0.
- Reset asserted in the same cycle as imem_ack → word discarded; refetch from RESET_PC; pc = 32'hFFFF_FFFC + 4 wraps to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS_32 front end: major opcode values, the
// fetch-unit state encoding and the default halt instruction word.
// No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

    // Major opcode values (instr[31:26]) seen by the ALU / register file
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGEZ  = 6'b000001;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // Instruction word that stops the fetch unit
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    // Fetch unit control states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        HOLD = 2'b10,
        HALT = 2'b11
    } fetch_state_e;

endpackage : mips_pkg

// File: rtl/next_pc_calc.sv
// -----------------------------------------------------------------------------
// next_pc_calc
// Combinational next program counter: pc + 4, plus the ALU byte offset when
// the branch is taken. 32-bit modulo arithmetic; the result is forced to a
// word address.
// Ports:
//   pc            in  32  current program counter
//   branch        in  1   branch taken
//   branch_offset in  32  signed byte offset (two's complement)
//   next_pc       out 32  following program counter, bits [1:0] = 0
// -----------------------------------------------------------------------------
module next_pc_calc (
    input  logic [31:0] pc,
    input  logic        branch,
    input  logic [31:0] branch_offset,
    output logic [31:0] next_pc
);

    logic [31:0] offset_s;
    logic [31:0] sum_s;

    // Select the branch offset and form the word-aligned sum
    always_comb begin
        offset_s = 32'd0;
        if (branch) begin
            offset_s = branch_offset;
        end else begin
            offset_s = 32'd0;
        end
        // Adding a signed offset as unsigned gives the right wrap modulo 2^32
        sum_s   = pc + 32'd4 + offset_s;
        next_pc = sum_s & 32'hFFFF_FFFC;
    end

endmodule : next_pc_calc

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Front end of the single-issue MIPS_32 datapath. Holds the PC, fetches one
// instruction per request/acknowledge handshake, presents the decoded fields
// until downstream signals exec_done, then advances the PC (taking the ALU
// branch decision into account). A fetched HALT_WORD stops the unit until reset.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   imem_req/imem_addr (out)        fetch request and byte address (= pc)
//   imem_ack/imem_rdata (in)        memory response
//   instr_valid (out)               fields below are valid
//   opcode/rs/rt/rd/funct/immediate decoded fields of the held instruction
//   pc (out)                        address of the held instruction
//   exec_done/branch/branch_offset  downstream consume + ALU branch result
//   halted (out)                    halt instruction fetched (sticky)
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  funct,
    output logic [15:0] immediate,
    output logic [31:0] pc,
    input  logic        exec_done,
    input  logic        branch,
    input  logic [31:0] branch_offset,
    output logic        halted
);

    fetch_state_e state_r;
    fetch_state_e state_next_s;
    logic [31:0]  pc_r;
    logic [31:0]  pc_next_s;
    logic [31:0]  pc_calc_s;
    logic [31:0]  instr_r;
    logic [31:0]  instr_next_s;
    logic         req_r;
    logic         valid_r;
    logic         halted_r;

    next_pc_calc u_next_pc (
        .pc            (pc_r),
        .branch        (branch),
        .branch_offset (branch_offset),
        .next_pc       (pc_calc_s)
    );

    // Next-state, next-pc and instruction-capture logic
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        instr_next_s = instr_r;
        case (state_r)
            IDLE: begin
                state_next_s = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    instr_next_s = imem_rdata;
                    if (imem_rdata == HALT_WORD) begin
                        state_next_s = HALT;
                    end else begin
                        state_next_s = HOLD;
                    end
                end else begin
                    state_next_s = REQ;
                end
            end
            HOLD: begin
                if (exec_done) begin
                    pc_next_s    = pc_calc_s;
                    state_next_s = REQ;
                end else begin
                    state_next_s = HOLD;
                end
            end
            HALT: begin
                // pc keeps the halt instruction's address
                state_next_s = HALT;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, pc, instruction register and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            pc_r     <= RESET_PC;
            instr_r  <= 32'd0;
            req_r    <= 1'b0;
            valid_r  <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            pc_r     <= pc_next_s;
            instr_r  <= instr_next_s;
            // Status flags are registered from the next state so they line
            // up with the state they describe
            req_r    <= (state_next_s == REQ);
            valid_r  <= (state_next_s == HOLD);
            halted_r <= (state_next_s == HALT);
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign pc          = pc_r;
    assign instr_valid = valid_r;
    assign halted      = halted_r;
    assign opcode      = instr_r[31:26];
    assign rs          = instr_r[25:21];
    assign rt          = instr_r[20:16];
    assign rd          = instr_r[15:11];
    assign funct       = instr_r[5:0];
    assign immediate   = instr_r[15:0];

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Self-checking bench: the bench plays instruction memory and downstream
// consumer, keeps the architectural PC in a transaction-level model and checks
// the DUT handshake, fields, pc and halt behaviour against it.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] HALT_W   = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] immediate;
    logic [31:0] pc;
    logic        exec_done;
    logic        branch;
    logic [31:0] branch_offset;
    logic        halted;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_pc;
    logic [31:0] held_word;

    instr_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .opcode        (opcode),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .funct         (funct),
        .immediate     (immediate),
        .pc            (pc),
        .exec_done     (exec_done),
        .branch        (branch),
        .branch_offset (branch_offset),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_held(input logic [31:0] w);
        chk("valid", {31'd0, instr_valid}, 32'd1);
        chk("req_in_hold", {31'd0, imem_req}, 32'd0);
        chk("opcode", {26'd0, opcode}, {26'd0, w[31:26]});
        chk("rs", {27'd0, rs}, {27'd0, w[25:21]});
        chk("rt", {27'd0, rt}, {27'd0, w[20:16]});
        chk("rd", {27'd0, rd}, {27'd0, w[15:11]});
        chk("funct", {26'd0, funct}, {26'd0, w[5:0]});
        chk("imm", {16'd0, immediate}, {16'd0, w[15:0]});
        chk("pc_hold", pc, model_pc);
    endtask

    // Memory side: request must stay stable for `delay` cycles, then ack
    task automatic fetch(input logic [31:0] word, input int delay);
        for (int i = 0; i < delay; i++) begin
            chk("req_wait", {31'd0, imem_req}, 32'd1);
            chk("addr_wait", imem_addr, model_pc);
            chk("valid_wait", {31'd0, instr_valid}, 32'd0);
            exec_done     = 1'($urandom % 2);
            branch        = 1'($urandom % 2);
            branch_offset = $urandom;
            imem_ack      = 1'b0;
            imem_rdata    = $urandom;
            step();
        end
        chk("req_ack", {31'd0, imem_req}, 32'd1);
        chk("addr_ack", imem_addr, model_pc);
        exec_done  = 1'b0;
        branch     = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        held_word  = word;
        if (word == HALT_W) begin
            chk("halted", {31'd0, halted}, 32'd1);
            chk("halt_req", {31'd0, imem_req}, 32'd0);
            chk("halt_valid", {31'd0, instr_valid}, 32'd0);
            chk("halt_pc", pc, model_pc);
        end else begin
            check_held(word);
        end
    endtask

    // Downstream side: noise for `idle` cycles, then consume with branch result
    task automatic execute(input logic br, input logic [31:0] off, input int idle);
        for (int i = 0; i < idle; i++) begin
            exec_done     = 1'b0;
            branch        = 1'($urandom % 2);
            branch_offset = $urandom;
            imem_ack      = 1'($urandom % 2);
            imem_rdata    = $urandom;
            step();
            check_held(held_word);
        end
        imem_ack      = 1'b0;
        exec_done     = 1'b1;
        branch        = br;
        branch_offset = off;
        step();
        exec_done     = 1'b0;
        branch        = 1'b0;
        branch_offset = $urandom;
        model_pc = (model_pc + 32'd4 + (br ? off : 32'd0)) & 32'hFFFF_FFFC;
        chk("valid_after_exec", {31'd0, instr_valid}, 32'd0);
        chk("req_after_exec", {31'd0, imem_req}, 32'd1);
        chk("addr_after_exec", imem_addr, model_pc);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT_W) begin
            w = 32'd0;
        end
        return w;
    endfunction

    initial begin
        logic [15:0] imm16;
        logic [31:0] off;
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0;
        exec_done = 1'b0; branch = 1'b0; branch_offset = 32'd0;
        held_word = 32'd0;
        model_pc = RESET_PC;
        step();
        step();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_fields", {opcode, rs, rt, rd, funct}, 32'd0);
        chk("rst_imm", {16'd0, immediate}, 32'd0);
        reset = 1'b0;
        step();
        chk("req_rise", {31'd0, imem_req}, 32'd1);
        chk("addr0", imem_addr, 32'd0);

        // Zero-wait fetch with known field values
        fetch(32'h2008_0005, 0);
        chk("addi_op", {26'd0, opcode}, 32'h8);
        chk("addi_rs", {27'd0, rs}, 32'd0);
        chk("addi_rt", {27'd0, rt}, 32'd8);
        chk("addi_imm", {16'd0, immediate}, 32'd5);
        execute(1'b0, 32'd0, 1);
        fetch(rand_word(), 3);
        execute(1'b0, 32'd0, 0);
        fetch(rand_word(), 1);
        execute(1'b0, 32'd0, 0);
        fetch(rand_word(), 0);
        execute(1'b0, 32'd0, 2);
        chk("at_0x10", imem_addr, 32'h10);

        // Backward branch from 0x10 and straight-line from 0x10
        fetch(rand_word(), 0);
        execute(1'b1, 32'hFFFF_FFF8, 2);
        chk("branch_back", imem_addr, 32'h0C);
        fetch(rand_word(), 0);
        execute(1'b0, 32'd0, 0);
        fetch(rand_word(), 0);
        execute(1'b0, 32'hFFFF_FFF8, 1);
        chk("no_branch", imem_addr, 32'h14);

        // exec_done/branch during REQ must be ignored
        for (int i = 0; i < 2; i++) begin
            exec_done = 1'b1; branch = 1'b1; branch_offset = $urandom;
            step();
            exec_done = 1'b0; branch = 1'b0;
            chk("req_exec_addr", imem_addr, model_pc);
            chk("req_exec_req", {31'd0, imem_req}, 32'd1);
            chk("req_exec_valid", {31'd0, instr_valid}, 32'd0);
        end

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            fetch(rand_word(), int'($urandom_range(0, 3)));
            imm16 = 16'($urandom);
            off = {{14{imm16[15]}}, imm16, 2'b00};
            execute(1'($urandom % 2), off, int'($urandom_range(0, 2)));
        end

        // Steer to 0x20 and halt there
        fetch(rand_word(), 0);
        execute(1'b1, 32'h20 - (model_pc + 32'd4), 0);
        chk("at_0x20", imem_addr, 32'h20);
        fetch(HALT_W, 1);
        for (int i = 0; i < 10; i++) begin
            imem_ack = 1'($urandom % 2); imem_rdata = $urandom;
            exec_done = 1'($urandom % 2); branch = 1'($urandom % 2);
            branch_offset = $urandom;
            step();
            chk("halt_stay", {31'd0, halted}, 32'd1);
            chk("halt_noreq", {31'd0, imem_req}, 32'd0);
            chk("halt_novalid", {31'd0, instr_valid}, 32'd0);
            chk("halt_pc_held", pc, 32'h20);
        end
        imem_ack = 1'b0; exec_done = 1'b0; branch = 1'b0;

        // Reset out of HALT
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_pc = RESET_PC;
        chk("rst2_pc", pc, RESET_PC);
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        step();
        chk("rst2_req", {31'd0, imem_req}, 32'd1);

        // Reset in the same cycle as ack: word discarded
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        reset = 1'b0; imem_ack = 1'b0;
        chk("rstack_valid", {31'd0, instr_valid}, 32'd0);
        chk("rstack_req", {31'd0, imem_req}, 32'd0);
        chk("rstack_op", {26'd0, opcode}, 32'd0);
        chk("rstack_pc", pc, RESET_PC);
        step();
        chk("refetch_req", {31'd0, imem_req}, 32'd1);
        chk("refetch_addr", imem_addr, RESET_PC);
        fetch(32'h8C22_0010, 2);

        // Wrap-around from 0xFFFF_FFFC
        execute(1'b1, 32'hFFFF_FFFC - (model_pc + 32'd4), 0);
        chk("at_top", imem_addr, 32'hFFFF_FFFC);
        fetch(rand_word(), 0);
        execute(1'b0, 32'd0, 0);
        chk("wrap", imem_addr, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_instr_fetch_unit
